// File: rtl/cpu_pkg.sv
// Shared CPU constants and the register-address type used by the write-back
// stage and its register-file read ports.
package cpu_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t   REG_ZERO     = 5'd0;
    localparam logic [31:0] BUBBLE_INSTR = 32'h0;

    // r0 is hardwired to zero, so a write to it never fires.
    function automatic logic write_fires(input logic we, input reg_addr_t addr);
        return we && (addr != REG_ZERO);
    endfunction

endpackage

// File: rtl/wb_regfile_read_port.sv
// One combinational register-file read port: r0 forces zero, otherwise a
// same-cycle write to the same address is forwarded ahead of the stored value.
module regfile_read_port
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic                  wr_fire_i,
    input  logic [REG_ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0]     wr_data_i,
    input  logic [DATA_W-1:0]     stored_i,
    output logic [DATA_W-1:0]     rd_data_o
);

    always_comb begin
        rd_data_o = '0;
        if (rd_addr_i == REG_ZERO) begin
            rd_data_o = '0;
        end else if (wr_fire_i && (wr_addr_i == rd_addr_i)) begin
            rd_data_o = wr_data_i;
        end else begin
            rd_data_o = stored_i;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects the WB value, commits it into the 32x32 register
// file, serves rs/rt/debug reads with write-first bypass, and keeps a commit trace.
module wb_regfile
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wb_reg_write,
    input  logic                  wb_mem_to_reg,
    input  logic [REG_ADDR_W-1:0] wb_write_reg,
    input  logic [DATA_W-1:0]     wb_alu_result,
    input  logic [DATA_W-1:0]     wb_read_data,
    input  logic [31:0]           wb_instr,
    input  logic [31:0]           wb_pc,
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0]     rs_data,
    output logic [DATA_W-1:0]     rt_data,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]     dbg_data,
    output logic                  commit_valid,
    output logic [31:0]           commit_pc,
    output logic                  commit_we,
    output logic [REG_ADDR_W-1:0] commit_reg,
    output logic [DATA_W-1:0]     commit_data,
    output logic [CNT_W-1:0]      retired_count
);

    logic [DATA_W-1:0]     regs_q [NUM_REGS];
    logic [DATA_W-1:0]     wdata;
    logic                  wr_fire;
    logic                  retire;

    logic                  commit_valid_q, commit_valid_d;
    logic [31:0]           commit_pc_q,    commit_pc_d;
    logic                  commit_we_q,    commit_we_d;
    logic [REG_ADDR_W-1:0] commit_reg_q,   commit_reg_d;
    logic [DATA_W-1:0]     commit_data_q,  commit_data_d;
    logic [CNT_W-1:0]      count_q,        count_d;

    always_comb begin
        wdata   = wb_mem_to_reg ? wb_read_data : wb_alu_result;
        wr_fire = write_fires(wb_reg_write, wb_write_reg);
        retire  = (wb_instr != BUBBLE_INSTR);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_fire) begin
            regs_q[wb_write_reg] <= wdata;
        end
    end

    regfile_read_port #(.DATA_W(DATA_W)) u_rs_port (
        .rd_addr_i (rs_addr),
        .wr_fire_i (wr_fire),
        .wr_addr_i (wb_write_reg),
        .wr_data_i (wdata),
        .stored_i  (regs_q[rs_addr]),
        .rd_data_o (rs_data)
    );

    regfile_read_port #(.DATA_W(DATA_W)) u_rt_port (
        .rd_addr_i (rt_addr),
        .wr_fire_i (wr_fire),
        .wr_addr_i (wb_write_reg),
        .wr_data_i (wdata),
        .stored_i  (regs_q[rt_addr]),
        .rd_data_o (rt_data)
    );

    regfile_read_port #(.DATA_W(DATA_W)) u_dbg_port (
        .rd_addr_i (dbg_addr),
        .wr_fire_i (wr_fire),
        .wr_addr_i (wb_write_reg),
        .wr_data_i (wdata),
        .stored_i  (regs_q[dbg_addr]),
        .rd_data_o (dbg_data)
    );

    // Bubbles (instr == 0) may still write but are neither traced nor counted.
    always_comb begin
        commit_valid_d = retire;
        commit_pc_d    = wb_pc;
        commit_we_d    = wr_fire && retire;
        commit_reg_d   = '0;
        commit_data_d  = '0;
        count_d        = count_q;
        if (commit_we_d) begin
            commit_reg_d  = wb_write_reg;
            commit_data_d = wdata;
        end
        if (retire) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            commit_valid_q <= 1'b0;
            commit_pc_q    <= '0;
            commit_we_q    <= 1'b0;
            commit_reg_q   <= '0;
            commit_data_q  <= '0;
            count_q        <= '0;
        end else begin
            commit_valid_q <= commit_valid_d;
            commit_pc_q    <= commit_pc_d;
            commit_we_q    <= commit_we_d;
            commit_reg_q   <= commit_reg_d;
            commit_data_q  <= commit_data_d;
            count_q        <= count_d;
        end
    end

    always_comb begin
        commit_valid  = commit_valid_q;
        commit_pc     = commit_pc_q;
        commit_we     = commit_we_q;
        commit_reg    = commit_reg_q;
        commit_data   = commit_data_q;
        retired_count = count_q;
    end

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

  localparam int CW = 4;

  localparam int K_RS    = 0;
  localparam int K_RT    = 1;
  localparam int K_DBG   = 2;
  localparam int K_CV    = 3;
  localparam int K_CPC   = 4;
  localparam int K_CWE   = 5;
  localparam int K_CREG  = 6;
  localparam int K_CDATA = 7;
  localparam int K_CNT   = 8;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] exp;
    string       name;
  } sb_entry_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wb_reg_write;
  logic          wb_mem_to_reg;
  logic [4:0]    wb_write_reg;
  logic [31:0]   wb_alu_result;
  logic [31:0]   wb_read_data;
  logic [31:0]   wb_instr;
  logic [31:0]   wb_pc;
  logic [4:0]    rs_addr;
  logic [4:0]    rt_addr;
  logic [31:0]   rs_data;
  logic [31:0]   rt_data;
  logic [4:0]    dbg_addr;
  logic [31:0]   dbg_data;
  logic          commit_valid;
  logic [31:0]   commit_pc;
  logic          commit_we;
  logic [4:0]    commit_reg;
  logic [31:0]   commit_data;
  logic [CW-1:0] retired_count;

  sb_entry_t sb[$];
  int cyc = 0;
  int passed = 0;
  int total = 0;

  wb_regfile #(.DATA_W(32), .CNT_W(CW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .wb_reg_write  (wb_reg_write),
    .wb_mem_to_reg (wb_mem_to_reg),
    .wb_write_reg  (wb_write_reg),
    .wb_alu_result (wb_alu_result),
    .wb_read_data  (wb_read_data),
    .wb_instr      (wb_instr),
    .wb_pc         (wb_pc),
    .rs_addr       (rs_addr),
    .rt_addr       (rt_addr),
    .rs_data       (rs_data),
    .rt_data       (rt_data),
    .dbg_addr      (dbg_addr),
    .dbg_data      (dbg_data),
    .commit_valid  (commit_valid),
    .commit_pc     (commit_pc),
    .commit_we     (commit_we),
    .commit_reg    (commit_reg),
    .commit_data   (commit_data),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sample(input int k);
    case (k)
      K_RS:    return rs_data;
      K_RT:    return rt_data;
      K_DBG:   return dbg_data;
      K_CV:    return 32'(commit_valid);
      K_CPC:   return commit_pc;
      K_CWE:   return 32'(commit_we);
      K_CREG:  return 32'(commit_reg);
      K_CDATA: return commit_data;
      default: return 32'(retired_count);
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        logic [31:0] act;
        act = sample(sb[i].kind);
        total++;
        if (act === sb[i].exp) begin
          passed++;
        end else begin
          $display("FAIL %s (cycle %0d): got 0x%08h, expected 0x%08h",
                   sb[i].name, cyc, act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  function automatic void chk(input int c, input int k, input logic [31:0] v, input string nm);
    sb_entry_t e;
    e.cyc  = c;
    e.kind = k;
    e.exp  = v;
    e.name = nm;
    sb.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input logic we, input logic m2r, input logic [4:0] wreg,
                        input logic [31:0] alu, input logic [31:0] rd,
                        input logic [31:0] instr, input logic [31:0] pc);
    wb_reg_write  = we;
    wb_mem_to_reg = m2r;
    wb_write_reg  = wreg;
    wb_alu_result = alu;
    wb_read_data  = rd;
    wb_instr      = instr;
    wb_pc         = pc;
  endtask

  task automatic set_rd(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dbg);
    rs_addr  = rs;
    rt_addr  = rt;
    dbg_addr = dbg;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n = 1'b0;
    set_wb(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    set_rd(5'd0, 5'd0, 5'd0);
    repeat (3) @(posedge clk);
    #1;
    chk(cyc, K_CV,  32'h0, "reset_commit_valid");
    chk(cyc, K_CWE, 32'h0, "reset_commit_we");
    chk(cyc, K_CPC, 32'h0, "reset_commit_pc");
    chk(cyc, K_CNT, 32'h0, "reset_count");
    reset_n = 1'b1;

    for (int unsigned i = 0; i < 32; i++) begin
      tick();
      set_rd(5'(i), 5'(31 - i), 5'(i));
      chk(cyc, K_RS,  32'h0, "reset_rs");
      chk(cyc, K_RT,  32'h0, "reset_rt");
      chk(cyc, K_DBG, 32'h0, "reset_dbg");
    end

    tick(); n = cyc;
    set_wb(1'b1, 1'b0, 5'd5, 32'h1234, 32'h0, 32'h20A51234, 32'h40);
    set_rd(5'd5, 5'd0, 5'd5);
    chk(n, K_RS,  32'h1234, "bypass_rs_r5");
    chk(n, K_RT,  32'h0,    "r0_rt");
    chk(n, K_DBG, 32'h1234, "bypass_dbg_r5");
    chk(n + 1, K_CV,    32'h1,    "a_commit_valid");
    chk(n + 1, K_CPC,   32'h40,   "a_commit_pc");
    chk(n + 1, K_CWE,   32'h1,    "a_commit_we");
    chk(n + 1, K_CREG,  32'h5,    "a_commit_reg");
    chk(n + 1, K_CDATA, 32'h1234, "a_commit_data");
    chk(n + 1, K_CNT,   32'h1,    "a_count");
    #1;
    total++;
    if (rs_data !== 32'h1234) begin
      $display("FAIL now_bypass_rs_r5: got 0x%08h", rs_data);
    end else begin
      passed++;
    end

    tick(); n = cyc;
    set_wb(1'b1, 1'b1, 5'd31, 32'h1, 32'hDEADBEEF, 32'h8FBF0000, 32'h44);
    set_rd(5'd31, 5'd5, 5'd31);
    chk(n, K_RS,  32'hDEADBEEF, "bypass_rs_load");
    chk(n, K_RT,  32'h1234,     "stored_rt_r5");
    chk(n, K_DBG, 32'hDEADBEEF, "bypass_dbg_load");
    chk(n + 1, K_CV,    32'h1,        "b_commit_valid");
    chk(n + 1, K_CPC,   32'h44,       "b_commit_pc");
    chk(n + 1, K_CWE,   32'h1,        "b_commit_we");
    chk(n + 1, K_CREG,  32'd31,       "b_commit_reg");
    chk(n + 1, K_CDATA, 32'hDEADBEEF, "b_commit_data");
    chk(n + 1, K_CNT,   32'h2,        "b_count");
    #1;
    total++;
    if (rs_data !== 32'hDEADBEEF) begin
      $display("FAIL now_bypass_rs_load: got 0x%08h", rs_data);
    end else begin
      passed++;
    end

    tick(); n = cyc;
    set_wb(1'b1, 1'b0, 5'd0, 32'hFFFF, 32'h0, 32'h2000FFFF, 32'h48);
    set_rd(5'd0, 5'd31, 5'd0);
    chk(n, K_RS,  32'h0,        "r0_rs_write");
    chk(n, K_RT,  32'hDEADBEEF, "stored_rt_r31");
    chk(n, K_DBG, 32'h0,        "r0_dbg_write");
    chk(n + 1, K_CV,    32'h1,  "c_commit_valid");
    chk(n + 1, K_CPC,   32'h48, "c_commit_pc");
    chk(n + 1, K_CWE,   32'h0,  "c_commit_we");
    chk(n + 1, K_CREG,  32'h0,  "c_commit_reg");
    chk(n + 1, K_CDATA, 32'h0,  "c_commit_data");
    chk(n + 1, K_CNT,   32'h3,  "c_count");
    #1;
    total++;
    if (rs_data !== 32'h0) begin
      $display("FAIL now_r0_rs_write: got 0x%08h", rs_data);
    end else begin
      passed++;
    end

    tick(); n = cyc;
    set_wb(1'b1, 1'b0, 5'd3, 32'h7, 32'h0, 32'h0, 32'h4C);
    set_rd(5'd3, 5'd3, 5'd3);
    chk(n, K_RS,  32'h7, "bypass_rs_r3");
    chk(n, K_RT,  32'h7, "bypass_rt_r3");
    chk(n, K_DBG, 32'h7, "bypass_dbg_r3");
    chk(n + 1, K_CV,  32'h0, "d_commit_valid");
    chk(n + 1, K_CWE, 32'h0, "d_commit_we");
    chk(n + 1, K_CNT, 32'h3, "d_count");
    #1;
    total++;
    if (rt_data !== 32'h7) begin
      $display("FAIL now_bypass_rt_r3: got 0x%08h", rt_data);
    end else begin
      passed++;
    end

    tick(); n = cyc;
    set_wb(1'b0, 1'b0, 5'd3, 32'd99, 32'h0, 32'h0, 32'h50);
    set_rd(5'd3, 5'd31, 5'd5);
    chk(n, K_RS,  32'h7,        "nowrite_rs_r3");
    chk(n, K_RT,  32'hDEADBEEF, "nowrite_rt_r31");
    chk(n, K_DBG, 32'h1234,     "nowrite_dbg_r5");
    chk(n + 1, K_CV,  32'h0, "e_commit_valid");
    chk(n + 1, K_CNT, 32'h3, "e_count");

    tick(); n = cyc;
    reset_n = 1'b0;
    set_wb(1'b1, 1'b0, 5'd4, 32'h9, 32'h0, 32'h20040009, 32'h54);
    set_rd(5'd4, 5'd5, 5'd31);
    chk(n, K_RS,  32'h9,        "reset_bypass_rs_r4");
    chk(n, K_RT,  32'h1234,     "prereset_rt_r5");
    chk(n, K_DBG, 32'hDEADBEEF, "prereset_dbg_r31");
    chk(n + 1, K_CV,    32'h0, "f_commit_valid");
    chk(n + 1, K_CPC,   32'h0, "f_commit_pc");
    chk(n + 1, K_CWE,   32'h0, "f_commit_we");
    chk(n + 1, K_CREG,  32'h0, "f_commit_reg");
    chk(n + 1, K_CDATA, 32'h0, "f_commit_data");
    chk(n + 1, K_CNT,   32'h0, "f_count");
    #1;
    total++;
    if (rs_data !== 32'h9) begin
      $display("FAIL now_reset_bypass_rs_r4: got 0x%08h", rs_data);
    end else begin
      passed++;
    end

    tick(); n = cyc;
    reset_n = 1'b1;
    set_wb(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    set_rd(5'd4, 5'd5, 5'd31);
    chk(n, K_RS,  32'h0, "postreset_rs_r4");
    chk(n, K_RT,  32'h0, "postreset_rt_r5");
    chk(n, K_DBG, 32'h0, "postreset_dbg_r31");
    #1;
    total++;
    if (rs_data !== 32'h0) begin
      $display("FAIL now_postreset_rs_r4: got 0x%08h", rs_data);
    end else begin
      passed++;
    end

    for (int i = 1; i <= 16; i++) begin
      tick(); n = cyc;
      set_wb(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'(i), 32'(32'h100 + 4 * i));
      chk(n + 1, K_CNT, 32'(i % 16), "wrap_count");
      if (i == 16) begin
        chk(n + 1, K_CV,  32'h1, "wrap_commit_valid");
        chk(n + 1, K_CPC, 32'h140, "wrap_commit_pc");
      end
    end

    tick();
    set_wb(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (3) tick();

    while (sb.size() > 0) begin
      sb_entry_t e;
      e = sb.pop_front();
      total++;
      $display("FAIL %s: never checked, expected 0x%08h at cycle %0d", e.name, e.exp, e.cyc);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
